// File: rtl/aska_biphasic_driver_pkg.sv
// ---------------------------------------------------------------------------
// aska_biphasic_driver_pkg
// Shared definitions for the ASKA biphasic driver slice:
//   - default widths and sequence lengths
//   - FSM state encoding (also exported on the debug state output)
//   - switch/DAC decode of a state and a small integer max helper
// ---------------------------------------------------------------------------
package aska_biphasic_driver_pkg;

  localparam int AMP_W_DEF        = 6;
  localparam int PHASE_W_DEF      = 3;
  localparam int DEAD_CYCLES_DEF  = 1;
  localparam int GAP_CYCLES_DEF   = 1;
  localparam int DISCH_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEAD1 = 3'd1,
    ST_CATH  = 3'd2,
    ST_GAP   = 3'd3,
    ST_ANOD  = 3'd4,
    ST_DEAD2 = 3'd5,
    ST_DISCH = 3'd6
  } state_t;

  // Electrode switch pattern for one state; drive=1 means the DAC carries
  // the latched amplitude.
  typedef struct packed {
    logic sw_cath;
    logic sw_anod;
    logic sw_short;
    logic drive;
  } sw_dec_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Every state closes at most one switch, so break-before-make follows
  // from the dead/gap states that sit between any two closing states.
  function automatic sw_dec_t decode_state(input state_t s);
    sw_dec_t d;
    d = '0;
    case (s)
      ST_CATH:  begin d.sw_cath  = 1'b1; d.drive = 1'b1; end
      ST_ANOD:  begin d.sw_anod  = 1'b1; d.drive = 1'b1; end
      ST_DISCH: begin d.sw_short = 1'b1; end
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/aska_biphasic_driver_if.sv
// ---------------------------------------------------------------------------
// aska_biphasic_driver_if
// Bundle between the NPG (master) and the biphasic driver (slave).
//   master -> slave : enable, pulse_start, amplitude, phase_code, clr_err
//   slave -> master : dac_code, sw_cath, sw_anod, sw_short, busy,
//                     pulse_done, overrun, dbg_state
// Handshake: pulse_start is a one-cycle request; it is taken only when
// busy==0 and enable==1 (busy is the inverse of ready). A request while
// busy is dropped and flagged on overrun; pulse_done answers every taken
// request exactly once.
// ---------------------------------------------------------------------------
interface aska_biphasic_driver_if
  import aska_biphasic_driver_pkg::*;
#(
  parameter int AMP_W   = AMP_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF
);

  logic               enable;
  logic               pulse_start;
  logic [AMP_W-1:0]   amplitude;
  logic [PHASE_W-1:0] phase_code;
  logic               clr_err;

  logic [AMP_W-1:0]   dac_code;
  logic               sw_cath;
  logic               sw_anod;
  logic               sw_short;
  logic               busy;
  logic               pulse_done;
  logic               overrun;
  state_t             dbg_state;

  modport master (
    output enable, pulse_start, amplitude, phase_code, clr_err,
    input  dac_code, sw_cath, sw_anod, sw_short, busy, pulse_done,
           overrun, dbg_state
  );

  modport slave (
    input  enable, pulse_start, amplitude, phase_code, clr_err,
    output dac_code, sw_cath, sw_anod, sw_short, busy, pulse_done,
           overrun, dbg_state
  );

endinterface

// File: rtl/aska_biphasic_driver_phase_timer.sv
// ---------------------------------------------------------------------------
// aska_biphasic_driver_phase_timer
// Loadable down-counter that times every FSM state. Loading N gives N+1
// cycles of residency: the counter reads N..0 and o_expire is high in the
// cycle it reads 0.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_load       load strobe (wins over counting)
//   i_load_val   value loaded
//   o_count      current count
//   o_expire     count == 0
// ---------------------------------------------------------------------------
module aska_biphasic_driver_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_expire = (r_count == '0);

endmodule

// File: rtl/aska_biphasic_driver.sv
// ---------------------------------------------------------------------------
// aska_biphasic_driver
// Turns each accepted NPG pulse strobe into one charge-balanced biphasic
// stimulus: DEAD1 -> CATH -> GAP -> ANOD -> DEAD2 -> DISCH -> IDLE.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    aska_biphasic_driver_if.slave (NPG inputs, DAC/switch outputs,
//          busy / pulse_done / overrun status, dbg_state)
// All outputs are registered and decoded from the state being entered, so
// they line up cycle-for-cycle with dbg_state.
// ---------------------------------------------------------------------------
module aska_biphasic_driver
  import aska_biphasic_driver_pkg::*;
#(
  parameter int AMP_W        = AMP_W_DEF,
  parameter int PHASE_W      = PHASE_W_DEF,
  parameter int DEAD_CYCLES  = DEAD_CYCLES_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter int DISCH_CYCLES = DISCH_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  aska_biphasic_driver_if.slave bus
);

  localparam int TMR_W = max_int(PHASE_W + 1,
                         max_int($clog2(DEAD_CYCLES + 1),
                         max_int($clog2(GAP_CYCLES + 1),
                                 $clog2(DISCH_CYCLES + 1))));

  localparam logic [TMR_W-1:0] DEAD_LOAD  = TMR_W'(DEAD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TMR_W-1:0] DISCH_LOAD = TMR_W'(DISCH_CYCLES - 1);

  state_t             r_state;
  logic [AMP_W-1:0]   r_amp;
  logic [PHASE_W-1:0] r_phase;
  logic [AMP_W-1:0]   r_dac;
  logic               r_sw_cath;
  logic               r_sw_anod;
  logic               r_sw_short;
  logic               r_busy;
  logic               r_done;
  logic               r_overrun;

  state_t             w_next_state;
  logic               w_load;
  logic [TMR_W-1:0]   w_load_val;
  logic               w_accept;
  logic               w_done;
  logic [TMR_W-1:0]   w_tmr_cnt;
  logic               w_tmr_exp;
  logic [TMR_W-1:0]   w_phase_load;
  sw_dec_t            w_dec;

  // A phase of phase_code+1 cycles needs the timer loaded with phase_code.
  assign w_phase_load = TMR_W'(r_phase);

  aska_biphasic_driver_phase_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_count    (w_tmr_cnt),
    .o_expire   (w_tmr_exp)
  );

  // Transition function; the timer is reloaded on every state change.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.enable && bus.pulse_start) begin
          w_accept = 1'b1;
          if (bus.amplitude == '0) begin
            // Zero amplitude: acknowledge without touching the electrode.
            w_done = 1'b1;
          end else begin
            w_next_state = ST_DEAD1;
            w_load       = 1'b1;
            w_load_val   = DEAD_LOAD;
          end
        end
      end
      ST_DEAD1: begin
        if (!bus.enable) begin
          // Nothing has been driven yet, so no discharge is needed.
          w_next_state = ST_IDLE;
          w_done       = 1'b1;
        end else if (w_tmr_exp) begin
          w_next_state = ST_CATH;
          w_load       = 1'b1;
          w_load_val   = w_phase_load;
        end
      end
      ST_CATH: begin
        if (!bus.enable) begin
          w_next_state = ST_DEAD2;
          w_load       = 1'b1;
          w_load_val   = DEAD_LOAD;
        end else if (w_tmr_exp) begin
          if (GAP_CYCLES > 0) begin
            w_next_state = ST_GAP;
            w_load_val   = GAP_LOAD;
          end else begin
            w_next_state = ST_ANOD;
            w_load_val   = w_phase_load;
          end
          w_load = 1'b1;
        end
      end
      ST_GAP: begin
        if (!bus.enable) begin
          w_next_state = ST_DEAD2;
          w_load       = 1'b1;
          w_load_val   = DEAD_LOAD;
        end else if (w_tmr_exp) begin
          w_next_state = ST_ANOD;
          w_load       = 1'b1;
          w_load_val   = w_phase_load;
        end
      end
      ST_ANOD: begin
        // Abort and normal end both go through DEAD2 into a full discharge.
        if (!bus.enable || w_tmr_exp) begin
          w_next_state = ST_DEAD2;
          w_load       = 1'b1;
          w_load_val   = DEAD_LOAD;
        end
      end
      ST_DEAD2: begin
        if (w_tmr_exp) begin
          w_next_state = ST_DISCH;
          w_load       = 1'b1;
          w_load_val   = DISCH_LOAD;
        end
      end
      ST_DISCH: begin
        if (w_tmr_exp) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // pulse_done is registered, so raise it when the cycle being entered
    // is the last DISCH cycle (timer will read 0 there).
    if (w_next_state == ST_DISCH) begin
      if (w_load ? (w_load_val == '0) : (w_tmr_cnt <= TMR_W'(1))) begin
        w_done = 1'b1;
      end
    end
  end

  assign w_dec = decode_state(w_next_state);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_amp      <= '0;
      r_phase    <= '0;
      r_dac      <= '0;
      r_sw_cath  <= 1'b0;
      r_sw_anod  <= 1'b0;
      r_sw_short <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_amp   <= bus.amplitude;
        r_phase <= bus.phase_code;
      end
      // CATH/ANOD are never entered straight from IDLE, so r_amp is
      // already the latched value whenever drive is set.
      r_dac      <= w_dec.drive ? r_amp : '0;
      r_sw_cath  <= w_dec.sw_cath;
      r_sw_anod  <= w_dec.sw_anod;
      r_sw_short <= w_dec.sw_short;
      r_busy     <= (w_next_state != ST_IDLE);
      r_done     <= w_done;
      // Set beats clear when both land in the same cycle.
      if ((r_state != ST_IDLE) && bus.pulse_start) begin
        r_overrun <= 1'b1;
      end else if (bus.clr_err) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.dac_code   = r_dac;
  assign bus.sw_cath    = r_sw_cath;
  assign bus.sw_anod    = r_sw_anod;
  assign bus.sw_short   = r_sw_short;
  assign bus.busy       = r_busy;
  assign bus.pulse_done = r_done;
  assign bus.overrun    = r_overrun;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_aska_biphasic_driver.sv
// ---------------------------------------------------------------------------
// tb_aska_biphasic_driver
// Directed bench for aska_biphasic_driver with default parameters
// (DEAD=1, GAP=1, DISCH=4). Expected per-cycle state sequences are written
// out by hand and queued; outputs follow from the expected state.
// ---------------------------------------------------------------------------
module tb_aska_biphasic_driver;
  import aska_biphasic_driver_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aska_biphasic_driver_if #(.AMP_W(6), .PHASE_W(3)) bus ();

  aska_biphasic_driver #(
    .AMP_W(6), .PHASE_W(3), .DEAD_CYCLES(1), .GAP_CYCLES(1), .DISCH_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int         n_chk = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];   // {pulse_done, state} per cycle
  bit         exp_ovr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] expv(input logic [2:0] st, input logic done,
                                       input int amp, input bit ovr);
    logic       c, a, s;
    logic [5:0] a6;
    a6 = amp[5:0];
    c  = (st == ST_CATH);
    a  = (st == ST_ANOD);
    s  = (st == ST_DISCH);
    return {st, (st != ST_IDLE), c, a, s, done, ovr, ((c | a) ? a6 : 6'd0)};
  endfunction

  function automatic logic [14:0] actv();
    return {bus.dbg_state, bus.busy, bus.sw_cath, bus.sw_anod, bus.sw_short,
            bus.pulse_done, bus.overrun, bus.dac_code};
  endfunction

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic d, input state_t s);
    exp_q.push_back({d, s});
  endtask

  // Normal sequence for phase length p (= phase_code+1).
  task automatic push_normal(input int p);
    push(1'b0, ST_DEAD1);
    repeat (p) push(1'b0, ST_CATH);
    push(1'b0, ST_GAP);
    repeat (p) push(1'b0, ST_ANOD);
    push(1'b0, ST_DEAD2);
    repeat (3) push(1'b0, ST_DISCH);
    push(1'b1, ST_DISCH);
    push(1'b0, ST_IDLE);
  endtask

  // ---------------- driver ----------------
  // Strobe in the current cycle, then walk the queued expectations one
  // cycle at a time while scrambling amplitude/phase_code.
  task automatic run_pulse(input string name, input int amp, input int pc,
                           input int inj_off, input int abort_off);
    logic [3:0] e;
    int         off;
    bus.amplitude   = 6'(amp);
    bus.phase_code  = 3'(pc);
    bus.pulse_start = 1'b1;
    step();
    bus.pulse_start = 1'b0;
    off = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("%s off%0d", name, off), actv(), expv(e[2:0], e[3], amp, exp_ovr));
      if (exp_q.size() == 0) break;
      bus.pulse_start = (off == inj_off);
      bus.clr_err     = (off == inj_off);
      if (off == abort_off) bus.enable = 1'b0;
      bus.amplitude  = 6'($urandom_range(0, 63));
      bus.phase_code = 3'($urandom_range(0, 7));
      step();
      if (off == inj_off) exp_ovr = 1'b1;
      bus.pulse_start = 1'b0;
      bus.clr_err     = 1'b0;
      off++;
    end
    bus.enable = 1'b1;
  endtask

  task automatic idle(input string name, input int n);
    repeat (n) begin
      step();
      chk(name, actv(), expv(ST_IDLE, 1'b0, 0, exp_ovr));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.enable      = 1'b0;
    bus.pulse_start = 1'b0;
    bus.amplitude   = '0;
    bus.phase_code  = '0;
    bus.clr_err     = 1'b0;
    exp_ovr         = 1'b0;
    reset           = 1'b1;
    repeat (3) step();
    chk("reset", actv(), expv(ST_IDLE, 1'b0, 0, 1'b0));
    reset = 1'b0;
    step();
    chk("post_reset", actv(), expv(ST_IDLE, 1'b0, 0, 1'b0));
    bus.enable = 1'b1;

    // Case 1: amp=20, phase_code=3.
    push_normal(4);
    run_pulse("c1", 20, 3, 0, 0);
    idle("c1_idle", 3);

    // Case 3: strobe (with clr_err) at N+4 while busy; set must win.
    push_normal(4);
    run_pulse("c3", 20, 3, 4, 0);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    exp_ovr     = 1'b0;
    chk("c3_clr", actv(), expv(ST_IDLE, 1'b0, 0, 1'b0));

    // Case 4: enable low during CATH at N+3.
    push(1'b0, ST_DEAD1);
    push(1'b0, ST_CATH);
    push(1'b0, ST_CATH);
    push(1'b0, ST_DEAD2);
    repeat (3) push(1'b0, ST_DISCH);
    push(1'b1, ST_DISCH);
    push(1'b0, ST_IDLE);
    run_pulse("c4", 33, 3, 0, 3);

    // Case 5: zero amplitude.
    push(1'b1, ST_IDLE);
    push(1'b0, ST_IDLE);
    run_pulse("c5", 0, 5, 0, 0);

    // Strobe while disabled: ignored, no overrun.
    bus.enable      = 1'b0;
    bus.amplitude   = 6'd40;
    bus.pulse_start = 1'b1;
    step();
    bus.pulse_start = 1'b0;
    chk("dis_strobe", actv(), expv(ST_IDLE, 1'b0, 0, 1'b0));
    bus.enable = 1'b1;
    idle("dis_idle", 1);

    // Case 2: strobes every 49 cycles, amplitude ramp, varied phase.
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        push(1'b1, ST_IDLE);
        push(1'b0, ST_IDLE);
        run_pulse("c2_p0", 0, 0, 0, 0);
        idle("c2_gap", 47);
      end else begin
        push_normal(i + 1);
        run_pulse($sformatf("c2_p%0d", i), i * 9, i, 0, 0);
        idle("c2_gap", 49 - (8 + 2 * (i + 1)));
      end
    end

    // Case 6: reset in the middle of ANOD with overrun set.
    bus.amplitude   = 6'd20;
    bus.phase_code  = 3'd3;
    bus.pulse_start = 1'b1;
    step();
    bus.pulse_start = 1'b0;
    step();
    step();
    bus.pulse_start = 1'b1;
    step();
    bus.pulse_start = 1'b0;
    repeat (4) step();
    chk("c6_anod", actv(), expv(ST_ANOD, 1'b0, 20, 1'b1));
    reset = 1'b1;
    step();
    exp_ovr = 1'b0;
    chk("c6_reset", actv(), expv(ST_IDLE, 1'b0, 0, 1'b0));
    reset = 1'b0;
    step();
    chk("c6_idle", actv(), expv(ST_IDLE, 1'b0, 0, 1'b0));
    push_normal(4);
    run_pulse("c6_after", 20, 3, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
